// File: rtl/input_pre_ctrl_if.sv
// rtl/input_pre_ctrl_if.sv - control, upstream byte stream and PE handshake bundle for input_pre_ctrl
interface input_pre_ctrl_if;
  logic       en;
  logic       start;
  logic [7:0] input_padding;
  logic [7:0] s_data;
  logic       s_vld;
  logic       s_rdy;
  logic [7:0] pre_din;
  logic       pre_din_vld;
  logic       pe_ready;
  logic       pe_start;
  logic [7:0] row_cnt;
  logic       busy;
  logic       frame_done;

  modport slave (
    input  en,
    input  start,
    input  input_padding,
    input  s_data,
    input  s_vld,
    input  pe_ready,
    output s_rdy,
    output pre_din,
    output pre_din_vld,
    output pe_start,
    output row_cnt,
    output busy,
    output frame_done
  );

  modport master (
    output en,
    output start,
    output input_padding,
    output s_data,
    output s_vld,
    output pe_ready,
    input  s_rdy,
    input  pre_din,
    input  pre_din_vld,
    input  pe_start,
    input  row_cnt,
    input  busy,
    input  frame_done
  );
endinterface

// File: rtl/input_pre_ctrl.sv
// rtl/input_pre_ctrl.sv - assembles padded rows byte by byte and hands each completed row to the PE array
module input_pre_ctrl #(
  parameter int         COLS    = 32,
  parameter int         ROWS    = 32,
  parameter logic [7:0] PAD_VAL = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input_pre_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PAD_L = 3'd1,
    LOAD  = 3'd2,
    PAD_R = 3'd3,
    ISSUE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [5:0] COL_LAST = 6'(COLS - 1);
  localparam logic [7:0] ROWS_L   = 8'(ROWS);

  state_t     state, state_n;
  logic [5:0] col_cnt;
  logic [7:0] row_cnt_q;
  logic       pad_l, pad_r;
  logic [7:0] pre_din_q;
  logic       vld_q;
  logic       pe_start_q;
  logic       frame_done_q;

  logic       s_rdy_c;
  logic       emit;
  logic [7:0] emit_byte;
  logic       col_inc, col_clr;
  logic       row_inc, row_clr;
  logic       latch_pad;
  logic       done_fire;

  logic unused_pad_bits;
  assign unused_pad_bits = ^bus.input_padding[6:1];

  always_comb begin
    state_n   = state;
    s_rdy_c   = 1'b0;
    emit      = 1'b0;
    emit_byte = PAD_VAL;
    col_inc   = 1'b0;
    col_clr   = 1'b0;
    row_inc   = 1'b0;
    row_clr   = 1'b0;
    latch_pad = 1'b0;
    done_fire = 1'b0;
    if (bus.en) begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            latch_pad = 1'b1;
            row_clr   = 1'b1;
            col_clr   = 1'b1;
            state_n   = bus.input_padding[7] ? PAD_L : LOAD;
          end
        end
        PAD_L: begin
          emit    = 1'b1;
          state_n = LOAD;
        end
        LOAD: begin
          s_rdy_c = 1'b1;
          if (bus.s_vld) begin
            emit      = 1'b1;
            emit_byte = bus.s_data;
            if (col_cnt == COL_LAST) begin
              col_clr = 1'b1;
              state_n = pad_r ? PAD_R : ISSUE;
            end else begin
              col_inc = 1'b1;
            end
          end
        end
        PAD_R: begin
          emit    = 1'b1;
          state_n = ISSUE;
        end
        ISSUE: begin
          if (bus.pe_ready) begin
            row_inc = 1'b1;
            if ((row_cnt_q + 8'd1) == ROWS_L) state_n = DONE;
            else                              state_n = pad_l ? PAD_L : LOAD;
          end
        end
        DONE: begin
          done_fire = 1'b1;
          state_n   = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // With en low every register freezes, including a byte registered just before the pause;
  // the output masks below hide it until en returns so nothing is lost or repeated.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      col_cnt      <= 6'd0;
      row_cnt_q    <= 8'd0;
      pad_l        <= 1'b0;
      pad_r        <= 1'b0;
      pre_din_q    <= 8'd0;
      vld_q        <= 1'b0;
      pe_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (bus.en) begin
      state        <= state_n;
      vld_q        <= emit;
      pe_start_q   <= row_inc;
      frame_done_q <= done_fire;
      if (emit) pre_din_q <= emit_byte;
      if (latch_pad) begin
        pad_l <= bus.input_padding[7];
        pad_r <= bus.input_padding[0];
      end
      if (col_clr)      col_cnt <= 6'd0;
      else if (col_inc) col_cnt <= col_cnt + 6'd1;
      if (row_clr)      row_cnt_q <= 8'd0;
      else if (row_inc) row_cnt_q <= row_cnt_q + 8'd1;
    end
  end

  assign bus.s_rdy       = s_rdy_c & ~rst;
  assign bus.pre_din     = pre_din_q;
  assign bus.pre_din_vld = vld_q & bus.en;
  assign bus.pe_start    = pe_start_q & bus.en;
  assign bus.frame_done  = frame_done_q & bus.en;
  assign bus.row_cnt     = row_cnt_q;
  assign bus.busy        = (state != IDLE);

endmodule
